spi_slave_param: RTL and testbench
==================================

// Module: spi_slave_param
// PURPOSE
//  Parametrised SPI slave between an external SPI master and the dual-port RAM.
//  Deserialises MOSI into DATA_W+2-bit command/data words for the RAM.
//  Serialises RAM read data onto MISO.
//  Adds over the fixed 8-bit slave: DATA_W generalisation, read-address tracking,
//  clean frame abort on ss_n, tx_valid timeout with error pulse.
//  Bit clock is the system clock: one MOSI/MISO bit per clk while ss_n is low.
// PARAMETERS
//  DATA_W      8   RAM data/address width; frame width RX_W = DATA_W+2
//  TX_TIMEOUT  16  max clk cycles to wait for tx_valid in READ_DATA (>=1)
// PORTS
//  clk       in   1         system clock, all logic on posedge
//  rst_n     in   1         asynchronous active-low reset
//  ss_n      in   1         slave select, active low; high ends/aborts frame
//  mosi      in   1         serial data in, MSB first
//  tx_valid  in   1         RAM read data valid
//  tx_data   in   DATA_W    RAM read data
//  miso      out  1         serial data out, MSB first
//  rx_valid  out  1         1-cycle pulse, rx_data holds complete frame
//  rx_data   out  DATA_W+2  {cmd[1:0], payload[DATA_W-1:0]}
//  tx_err    out  1         1-cycle pulse on tx_valid timeout
// BEHAVIOUR
//  Reset (async): state=IDLE; miso=0, rx_valid=0, rx_data=0, tx_err=0.
//    Bit counter cleared; rd_addr_seen flag cleared.
//  FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, HOLD.
//  Any state: ss_n=1 at a clk edge -> IDLE next cycle; counters cleared; miso=0;
//    partial frame discarded (no rx_valid); rd_addr_seen kept.
//  IDLE: ss_n=0 at edge -> CHK_CMD (no bit captured this edge).
//  CHK_CMD: mosi captured as frame bit RX_W-1. Next state:
//    mosi=0 -> WRITE; mosi=1 & !rd_addr_seen -> READ_ADD;
//    mosi=1 & rd_addr_seen -> READ_DATA.
//  WRITE/READ_ADD/READ_DATA: shift remaining RX_W-1 bits, MSB first.
//    At the edge capturing bit 0: rx_data <= {shift, mosi}; rx_valid=1 for exactly 1 cycle.
//    Frame latency: rx_valid high RX_W+1 edges after ss_n first sampled low.
//    rx_data bits are forwarded exactly as received, whatever state decoded them.
//  Frame completion updates rd_addr_seen:
//    READ_ADD sets it; READ_DATA clears it; WRITE leaves it.
//  After frame: WRITE/READ_ADD -> HOLD; READ_DATA -> TX_WAIT.
//  TX_WAIT: wait counter increments each cycle.
//    tx_valid=1 at edge -> latch tx_data, miso=tx_data[DATA_W-1], -> TX_SHIFT.
//    Counter reaches TX_TIMEOUT with no tx_valid -> tx_err 1-cycle pulse, miso=0, -> HOLD.
//    tx_valid while not in TX_WAIT is ignored.
//  TX_SHIFT: each edge presents the next lower bit; every bit held exactly 1 cycle.
//    After bit 0's cycle, miso=0 -> HOLD.
//  HOLD: mosi ignored, miso=0, until ss_n=1 -> IDLE.
//  Simultaneous ss_n=1 and last bit / tx_valid at the same edge: ss_n wins.
//    No rx_valid; tx_data not latched.
//  Counters sized $clog2(RX_W) / $clog2(TX_TIMEOUT+1).
//  Counters saturate and never wrap; no combinational input->output paths.
// TESTING (DATA_W=8)
//  1 rst_n low mid-WRITE frame -> miso=0, rx_valid=0, rx_data=0, next frame decodes from IDLE.
//  2 frame 10'b00_1010_0101 -> single rx_valid pulse, rx_data=10'h0A5, FSM in HOLD, miso=0.
//  3 frame 10'b10_0000_0011 then frame 10'b11_0000_0000, tx_valid with tx_data=8'hC3
//      -> rx_data=10'h203 then 10'h300; miso=1,1,0,0,0,0,1,1, then 0; rd_addr_seen cleared.
//  4 ss_n high after 5 bits of a write -> no rx_valid; following frame 10'b01_1111_0000
//      -> rx_data=10'h1F0.
//  5 read-data frame, tx_valid held low 16 cycles -> tx_err pulse at cycle 16, miso stays 0.
//  6 frame 10'b11_0101_0101 with rd_addr_seen=0 -> decoded READ_ADD, rx_data=10'h355,
//      no MISO data, flag set.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave bridging an external master to the dual-port RAM: deserialises
// DATA_W+2-bit command frames and serialises RAM read data back onto MISO.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | frame not started, waiting for ss_n low
// S_CHK_CMD   | capturing frame MSB, which selects write or read
// S_WRITE     | shifting in a write frame (address or data)
// S_READ_ADD  | shifting in a read-address frame
// S_READ_DATA | shifting in a read-data request frame
// S_TX_WAIT   | waiting for RAM read data, bounded by TX_TIMEOUT
// S_TX_SHIFT  | shifting the read byte out on MISO, MSB first
// S_HOLD      | frame done, ignoring MOSI until ss_n goes high
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              tx_err
);

    localparam int RX_W = DATA_W + 2;
    localparam int BC_W = $clog2(RX_W);
    localparam int WT_W = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK_CMD, S_WRITE, S_READ_ADD,
        S_READ_DATA, S_TX_WAIT, S_TX_SHIFT, S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [WT_W-1:0]   r_wait_cnt;
    logic [RX_W-2:0]   r_shift;
    logic [DATA_W-1:0] r_tx_sh;
    logic              r_rd_addr_seen;
    logic              r_miso;
    logic              r_rx_valid;
    logic [RX_W-1:0]   r_rx_data;
    logic              r_tx_err;
    logic              w_last_bit;
    logic              w_timeout;
    logic              w_tx_done;

    assign w_last_bit = (r_bit_cnt == BC_W'(RX_W - 1));
    assign w_timeout  = (r_wait_cnt == WT_W'(TX_TIMEOUT - 1));
    assign w_tx_done  = (r_bit_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (ss_n) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      w_next = S_CHK_CMD;
                S_CHK_CMD:   w_next = !mosi ? S_WRITE :
                                      (r_rd_addr_seen ? S_READ_DATA : S_READ_ADD);
                S_WRITE,
                S_READ_ADD:  if (w_last_bit) w_next = S_HOLD;
                S_READ_DATA: if (w_last_bit) w_next = S_TX_WAIT;
                S_TX_WAIT:   if (tx_valid) w_next = S_TX_SHIFT;
                             else if (w_timeout) w_next = S_HOLD;
                S_TX_SHIFT:  if (w_tx_done) w_next = S_HOLD;
                S_HOLD:      w_next = S_HOLD;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_shift        <= '0;
            r_tx_sh        <= '0;
            r_rd_addr_seen <= 1'b0;
            r_miso         <= 1'b0;
            r_rx_valid     <= 1'b0;
            r_rx_data      <= '0;
            r_tx_err       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_err   <= 1'b0;
            // ss_n high takes priority over any bit or tx_valid at the same edge
            if (ss_n) begin
                r_bit_cnt  <= '0;
                r_wait_cnt <= '0;
                r_miso     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_bit_cnt  <= '0;
                        r_wait_cnt <= '0;
                        r_miso     <= 1'b0;
                    end
                    S_CHK_CMD: begin
                        r_shift   <= {{(RX_W-2){1'b0}}, mosi};
                        r_bit_cnt <= BC_W'(1);
                    end
                    S_WRITE, S_READ_ADD, S_READ_DATA: begin
                        if (w_last_bit) begin
                            r_rx_data  <= {r_shift, mosi};
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_wait_cnt <= '0;
                            if (r_state == S_READ_ADD)  r_rd_addr_seen <= 1'b1;
                            if (r_state == S_READ_DATA) r_rd_addr_seen <= 1'b0;
                        end else begin
                            r_shift   <= {r_shift[RX_W-3:0], mosi};
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                    S_TX_WAIT: begin
                        if (tx_valid) begin
                            r_miso    <= tx_data[DATA_W-1];
                            r_tx_sh   <= {tx_data[DATA_W-2:0], 1'b0};
                            r_bit_cnt <= BC_W'(DATA_W - 1);
                        end else if (w_timeout) begin
                            r_tx_err <= 1'b1;
                            r_miso   <= 1'b0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WT_W'(1);
                        end
                    end
                    S_TX_SHIFT: begin
                        if (w_tx_done) begin
                            r_miso <= 1'b0;
                        end else begin
                            r_miso    <= r_tx_sh[DATA_W-1];
                            r_tx_sh   <= {r_tx_sh[DATA_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - BC_W'(1);
                        end
                    end
                    default: r_miso <= 1'b0;
                endcase
            end
        end
    end

    assign miso     = r_miso;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign tx_err   = r_tx_err;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param (DATA_W=8, TX_TIMEOUT=16) with a frame-level
// reference model tracking the read-address flag and last received word.
module tb_spi_slave_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       miso;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_err;

    int total = 0;
    int bad   = 0;

    logic       m_seen = 1'b0;
    logic [9:0] m_last = '0;

    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
        .tx_valid(tx_valid), .tx_data(tx_data), .miso(miso),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // abort_at: bit index (0..9) at which ss_n rises together with that bit, -1 for none.
    // tx_delay: idle cycles before tx_valid; >=16 means the RAM never answers.
    task automatic run_frame(input logic [9:0] f, input int abort_at,
                             input int tx_delay, input logic [7:0] txd);
        logic is_rd;
        ss_n = 1'b0; mosi = 1'($urandom); tx_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            mosi = f[9-i];
            if (i == abort_at) ss_n = 1'b1;
            tick();
            total++;
            if (rx_valid !== (i == 9 && abort_at < 0)) begin
                bad++; $display("FAIL rx_valid bit%0d got=%b exp=%b", i, rx_valid, (i == 9 && abort_at < 0));
            end
            total++;
            if (miso !== 1'b0) begin bad++; $display("FAIL miso_rx bit%0d got=%b exp=0", i, miso); end
            if (ss_n) break;
        end
        if (abort_at >= 0) begin
            total++;
            if (rx_data !== m_last) begin bad++; $display("FAIL abort_rx_data got=%h exp=%h", rx_data, m_last); end
            tick();
            return;
        end
        total++;
        if (rx_data !== f) begin bad++; $display("FAIL rx_data got=%h exp=%h", rx_data, f); end
        m_last = f;
        is_rd = f[9] && m_seen;
        if (f[9]) m_seen = !m_seen;
        if (is_rd) begin
            for (int d = 0; d < tx_delay && d < 16; d++) begin
                tx_valid = 1'b0;
                tick();
                total++;
                if (tx_err !== (d == 15)) begin bad++; $display("FAIL tx_err wait%0d got=%b exp=%b", d, tx_err, (d == 15)); end
                total++;
                if (miso !== 1'b0) begin bad++; $display("FAIL miso_wait%0d got=%b exp=0", d, miso); end
            end
            if (tx_delay >= 16) begin
                tx_valid = 1'b1; tx_data = 8'hFF;
                tick();
                tx_valid = 1'b0;
                total++;
                if (tx_err !== 1'b0 || miso !== 1'b0) begin
                    bad++; $display("FAIL after_timeout tx_err=%b miso=%b exp 0 0", tx_err, miso);
                end
            end else begin
                tx_valid = 1'b1; tx_data = txd;
                tick();
                tx_valid = 1'b0; tx_data = 8'($urandom);
                for (int k = 7; k >= 0; k--) begin
                    total++;
                    if (miso !== txd[k]) begin bad++; $display("FAIL miso_tx bit%0d got=%b exp=%b", k, miso, txd[k]); end
                    tick();
                end
                total++;
                if (miso !== 1'b0) begin bad++; $display("FAIL miso_after_tx got=%b exp=0", miso); end
            end
        end else begin
            tx_valid = 1'b1; tx_data = 8'hFF;
            tick();
            tick();
            tx_valid = 1'b0;
            total++;
            if (miso !== 1'b0 || tx_err !== 1'b0) begin
                bad++; $display("FAIL hold_ignore miso=%b tx_err=%b exp 0 0", miso, tx_err);
            end
        end
        ss_n = 1'b1;
        tick();
        total++;
        if (miso !== 1'b0 || rx_valid !== 1'b0) begin
            bad++; $display("FAIL frame_end miso=%b rx_valid=%b exp 0 0", miso, rx_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tick(); tick();
        total++;
        if ({miso, rx_valid, rx_data, tx_err} !== 13'd0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {miso, rx_valid, rx_data, tx_err});
        end
        rst_n = 1'b1;
        tick();
        run_frame(10'h3FF, -1, 0, 8'h00);   // read-address frame sets the flag
        ss_n = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin mosi = 1'b0; tick(); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({miso, rx_valid, rx_data, tx_err} !== 13'd0) begin
            bad++; $display("FAIL reset_mid_frame got=%b exp=0", {miso, rx_valid, rx_data, tx_err});
        end
        m_seen = 1'b0; m_last = '0;
        ss_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(10'h3AA, -1, 0, 8'hFF);   // flag cleared by reset: must decode as READ_ADD
        run_frame(10'h300, -1, 0, 8'h81);   // now a read-data frame
    endtask

    task automatic test_write();
        run_frame(10'h0A5, -1, 0, 8'h00);
    endtask

    task automatic test_read_sequence();
        run_frame(10'h203, -1, 0, 8'h00);
        run_frame(10'h300, -1, 3, 8'hC3);
        total++;
        if (m_seen !== 1'b0) begin bad++; $display("FAIL model_flag got=%b exp=0", m_seen); end
    endtask

    task automatic test_abort();
        run_frame(10'h0FF, 5, 0, 8'h00);
        run_frame(10'h1F0, -1, 0, 8'h00);
    endtask

    task automatic test_read_addr_only();
        run_frame(10'h355, -1, 0, 8'hFF);
    endtask

    task automatic test_timeout();
        run_frame(10'h3C3, -1, 16, 8'h00);
    endtask

    task automatic test_simultaneous();
        run_frame(10'h2AA, 9, 0, 8'h00);    // ss_n rises with last bit: discarded, flag kept
        run_frame(10'h211, -1, 0, 8'h00);
        run_frame(10'h3F0, -1, 0, 8'h5A);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            logic [9:0] f;
            int ab, dl;
            f  = 10'($urandom);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
            dl = int'($urandom_range(0, 20));
            run_frame(f, ab, dl, 8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_sequence();
        test_abort();
        test_read_addr_only();
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
